// File: rtl/tt_sweep_if.sv
// Handshake bundle between the truth-table sweeper and its test environment.
// The master side owns start/abort/c/expected; the sweeper (slave) owns the rest.
interface tt_sweep_if #(
    parameter int N_IN = 2
);
    localparam int NCOMB = 1 << N_IN;

    logic             start;
    logic             abort;
    logic [N_IN-1:0]  stim;
    logic             c;
    logic             busy;
    logic             done;
    logic [NCOMB-1:0] result;
    logic [NCOMB-1:0] expected;
    logic             pass;

    modport master (
        output start, abort, c, expected,
        input  stim, busy, done, result, pass
    );

    modport slave (
        input  start, abort, c, expected,
        output stim, busy, done, result, pass
    );
endinterface

// File: rtl/tt_sweep.sv
// Self-running truth-table sweep: steps stim through every combination, waits
// SETTLE_CYC cycles per step and captures c into result. Macro TT_SWEEP_CHECK_EN adds a pass/fail compare.
module tt_sweep #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    tt_sweep_if.slave  bus
);
    localparam int              NCOMB     = 1 << N_IN;
    localparam logic [7:0]      LAST_CNT  = 8'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] LAST_STIM = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] ONE_STIM  = N_IN'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [N_IN-1:0]  r_stim;
    logic             r_busy;
    logic             r_done;
    logic [NCOMB-1:0] r_result;
    logic [NCOMB-1:0] w_result_next;
    logic             w_accept;
    logic             w_sample;
    logic             w_final;

    // Capture view with the current c folded into its slot; the final compare needs it.
    always_comb begin
        w_result_next         = r_result;
        w_result_next[r_stim] = bus.c;
    end

    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_sample = (r_state == ST_SETTLE) && !bus.abort && (r_cnt == LAST_CNT);
    assign w_final  = w_sample && (r_stim == LAST_STIM);

    // Sweep sequencer: abort has priority over sampling in SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_stim   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state  <= ST_SETTLE;
                        r_stim   <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_cnt    <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_stim  <= '0;
                        r_busy  <= 1'b0;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_result <= w_result_next;
                        r_cnt    <= 8'd0;
                        if (r_stim != LAST_STIM) begin
                            r_stim <= r_stim + ONE_STIM;
                        end else begin
                            r_stim  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                    r_stim  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TT_SWEEP_CHECK_EN
    logic r_pass;

    // Verdict is struck on the final sample and cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
        end else if (w_accept) begin
            r_pass <= 1'b0;
        end else if (w_final) begin
            r_pass <= (w_result_next == bus.expected);
        end
    end

    assign bus.pass = r_pass;
`else
    assign bus.pass = 1'b0;
`endif

    assign bus.stim   = r_stim;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: table of UUT sweeps on a SETTLE_CYC=4 instance plus
// hand-written abort, reset, start-while-busy and SETTLE_CYC=1 sequences.
module tb_tt_sweep;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_sweep_if #(.N_IN(2)) bus4();
    tt_sweep_if #(.N_IN(2)) bus1();

    logic [1:0] op4 = 2'd0;
    logic [1:0] op1 = 2'd0;

    // Small UUT library: 0=AND 1=OR 2=XOR 3=NAND, stim[1]=a, stim[0]=b
    function automatic logic uut(input logic [1:0] op, input logic [1:0] s);
        case (op)
            2'd0:    return s[1] & s[0];
            2'd1:    return s[1] | s[0];
            2'd2:    return s[1] ^ s[0];
            default: return ~(s[1] & s[0]);
        endcase
    endfunction

    assign bus4.c = uut(op4, bus4.stim);
    assign bus1.c = uut(op1, bus1.stim);

    tt_sweep #(.N_IN(2), .SETTLE_CYC(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    tt_sweep #(.N_IN(2), .SETTLE_CYC(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [1:0] op;
        logic [3:0] res;
        logic [3:0] expct;
        logic       pass;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pass_exp(input logic p);
`ifdef TT_SWEEP_CHECK_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_sweep(input logic [1:0] op, input logic [3:0] exp_tt,
                             input logic [3:0] expct, input logic exp_pass, input int pulse_at);
        int done_at;
        op4           = op;
        bus4.expected = expct;
        bus4.start    = 1'b1;
        exp_q.push_back(exp_tt);
        tick();
        bus4.start = 1'b0;
        chk("busy_after_start", bus4.busy, 1);
        chk("pass_cleared", bus4.pass, 0);
        done_at = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            if (k == pulse_at) bus4.start = 1'b1;
            tick();
            bus4.start = 1'b0;
            if (bus4.done) done_at = k;
            else chk("stim_seq", bus4.stim, k / 4);
        end
        chk("done_edge", done_at, 16);
        if (done_at != 0) begin
            chk("result", bus4.result, exp_q.pop_front());
            chk("busy_in_done", bus4.busy, 0);
            chk("stim_in_done", bus4.stim, 0);
            chk("pass", bus4.pass, exp_pass);
            tick();
            chk("done_one_cycle", bus4.done, 0);
            chk("result_hold", bus4.result, exp_tt);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int dn;
        int k;
        bus4.start = 1'b0; bus4.abort = 1'b0; bus4.expected = 4'd0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.expected = 4'd0;

        vecs[0] = '{op: 2'd0, res: 4'b1000, expct: 4'b1000, pass: 1'b1};
        vecs[1] = '{op: 2'd1, res: 4'b1110, expct: 4'b1110, pass: 1'b1};
        vecs[2] = '{op: 2'd1, res: 4'b1110, expct: 4'b1111, pass: 1'b0};
        vecs[3] = '{op: 2'd2, res: 4'b0110, expct: 4'b0110, pass: 1'b1};
        vecs[4] = '{op: 2'd3, res: 4'b0111, expct: 4'b0000, pass: 1'b0};

        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_stim", bus4.stim, 0);
        chk("rst_busy", bus4.busy, 0);
        chk("rst_done", bus4.done, 0);
        chk("rst_result", bus4.result, 0);
        chk("rst_pass", bus4.pass, 0);

        for (int i = 0; i < 5; i++)
            run_sweep(vecs[i].op, vecs[i].res, vecs[i].expct, pass_exp(vecs[i].pass), 0);

        // start pulse mid-sweep must not restart it
        run_sweep(2'd0, 4'b1000, 4'b1000, pass_exp(1'b1), 5);

        // abort and start together in IDLE: abort wins
        bus4.start = 1'b1; bus4.abort = 1'b1;
        tick();
        bus4.start = 1'b0; bus4.abort = 1'b0;
        chk("abort_beats_start", bus4.busy, 0);

        // abort at e6 while stim==01
        op4 = 2'd0;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        repeat (5) tick();
        chk("pre_abort_stim", bus4.stim, 1);
        bus4.abort = 1'b1;
        tick();
        bus4.abort = 1'b0;
        chk("abort_busy", bus4.busy, 0);
        chk("abort_stim", bus4.stim, 0);
        chk("abort_result", bus4.result, 0);
        dn = 0;
        repeat (20) begin
            tick();
            if (bus4.done) dn = 1;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_pass", bus4.pass, 0);

        // async reset during stim==10 with an OR UUT so result is non-zero beforehand
        op4 = 2'd1;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        repeat (9) tick();
        chk("pre_reset_stim", bus4.stim, 2);
        chk("pre_reset_result", bus4.result, 4'b0010);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_stim", bus4.stim, 0);
        chk("mid_rst_busy", bus4.busy, 0);
        chk("mid_rst_done", bus4.done, 0);
        chk("mid_rst_result", bus4.result, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_sweep(2'd0, 4'b1000, 4'b1000, pass_exp(1'b1), 0);

        // SETTLE_CYC=1 XOR with start held high throughout
        op1 = 2'd2;
        bus1.expected = 4'b0110;
        bus1.start = 1'b1;
        exp_q.push_back(4'b0110);
        tick();
        dn = 0;
        for (k = 1; k <= 10 && dn == 0; k++) begin
            tick();
            if (bus1.done) dn = k;
        end
        chk("s1_done_edge", dn, 4);
        chk("s1_result", bus1.result, exp_q.pop_front());
        tick();
        chk("s1_idle_busy", bus1.busy, 0);
        chk("s1_idle_done", bus1.done, 0);
        tick();
        chk("s1_restart_busy", bus1.busy, 1);
        bus1.start = 1'b0;
        exp_q.push_back(4'b0110);
        dn = 0;
        for (k = 1; k <= 10 && dn == 0; k++) begin
            tick();
            if (bus1.done) dn = k;
        end
        chk("s1_second_done", dn, 4);
        chk("s1_second_result", bus1.result, exp_q.pop_front());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
